// File: rtl/loadable_instruction_ram_pkg.sv
// Shared definitions for the loadable instruction RAM: controller states and the
// halt word a decoder can match to recognise an out-of-range fetch.
package loadable_instruction_ram_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } lir_state_e;

  localparam int LIR_DATA_WIDTH = 32;
  localparam logic [LIR_DATA_WIDTH-1:0] LIR_HALT_WORD = '0;

  function automatic logic lir_is_halt(input logic [LIR_DATA_WIDTH-1:0] word);
    return word == LIR_HALT_WORD;
  endfunction

endpackage

// File: rtl/loadable_instruction_ram_if.sv
// Loader and fetch bus of the loadable instruction RAM; master is the loader/CPU
// side, slave is the RAM block.
interface loadable_instruction_ram_if
  import loadable_instruction_ram_pkg::*;
#(
  parameter int DATA_WIDTH = LIR_DATA_WIDTH,
  parameter int ADDR_WIDTH = 10
);

  logic                  load_start;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;
  logic                  load_ready;
  logic                  load_error;
  logic [ADDR_WIDTH:0]   program_length;
  logic                  cpu_hold;
  logic                  fetch_enable;
  logic [ADDR_WIDTH-1:0] fetch_address;
  logic [DATA_WIDTH-1:0] fetch_data;
  logic                  fetch_valid;
  logic                  fetch_fault;

  modport master (
    output load_start, load_valid, load_data, load_last, fetch_enable, fetch_address,
    input  load_ready, load_error, program_length, cpu_hold,
           fetch_data, fetch_valid, fetch_fault
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last, fetch_enable, fetch_address,
    output load_ready, load_error, program_length, cpu_hold,
           fetch_data, fetch_valid, fetch_fault
  );

endinterface

// File: rtl/loadable_instruction_ram_core.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Contents are never cleared; only the read register resets.
module instruction_ram_core #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [IDX_W-1:0]      wr_idx, rd_idx;

  // Callers keep both addresses below DEPTH, so dropping the upper bits is safe.
  assign wr_idx = wr_addr[IDX_W-1:0];
  assign rd_idx = rd_addr[IDX_W-1:0];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/loadable_instruction_ram.sv
// Instruction memory with a runtime download port; holds the CPU in stall until a
// program has been loaded and flags fetches beyond the loaded program.
//
// state    | meaning
// ST_EMPTY | no program since reset, waiting for load_start
// ST_LOAD  | accepting program beats, CPU held
// ST_RUN   | program valid, fetches serviced
module loadable_instruction_ram
  import loadable_instruction_ram_pkg::*;
#(
  parameter int DATA_WIDTH = LIR_DATA_WIDTH,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD = DATA_WIDTH'(LIR_HALT_WORD)
) (
  input logic clock,
  input logic reset,
  loadable_instruction_ram_if.slave bus
);

  localparam int LEN_W = ADDR_WIDTH + 1;
  localparam logic [LEN_W-1:0]      DEPTH_LEN = LEN_W'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);

  lir_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic                  err_q, err_d;
  logic                  fvalid_q, fvalid_d;
  logic                  ffault_q, ffault_d;

  logic                  load_ready;
  logic                  accept;
  logic                  fetch_go;
  logic                  in_range;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;

  // A restart pulse blocks any beat presented in the same cycle.
  assign load_ready = (state_q == ST_LOAD) && !bus.load_start;
  assign accept     = load_ready && bus.load_valid;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    err_d   = err_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (bus.load_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          len_d   = '0;
        end
      end
      ST_LOAD: begin
        if (bus.load_start) begin
          ptr_d = '0;
          len_d = '0;
        end else if (accept) begin
          ptr_d = ptr_q + 1'b1;
          if (bus.load_last) begin
            len_d   = {1'b0, ptr_q} + 1'b1;
            state_d = ST_RUN;
          end else if (ptr_q == LAST_PTR) begin
            len_d   = DEPTH_LEN;
            err_d   = 1'b1;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (bus.load_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          len_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // The compare is done at ADDR_WIDTH+1 bits so a length of DEPTH never wraps.
  assign fetch_go = bus.fetch_enable && (state_q == ST_RUN);
  assign in_range = {1'b0, bus.fetch_address} < len_q;
  assign rd_en    = fetch_go && in_range;

  always_comb begin
    fvalid_d = fetch_go;
    ffault_d = ffault_q;
    if (fetch_go) begin
      ffault_d = !in_range;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      ptr_q    <= '0;
      len_q    <= '0;
      err_q    <= 1'b0;
      fvalid_q <= 1'b0;
      ffault_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      len_q    <= len_d;
      err_q    <= err_d;
      fvalid_q <= fvalid_d;
      ffault_q <= ffault_d;
    end
  end

  instruction_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_core (
    .clock   (clock),
    .reset   (reset),
    .we      (accept && !reset),
    .wr_addr (ptr_q),
    .wr_data (bus.load_data),
    .rd_en   (rd_en),
    .rd_addr (bus.fetch_address),
    .rd_data (rd_data)
  );

  assign bus.load_ready     = load_ready;
  assign bus.load_error     = err_q;
  assign bus.program_length = len_q;
  assign bus.cpu_hold       = (state_q != ST_RUN);
  assign bus.fetch_valid    = fvalid_q;
  assign bus.fetch_fault    = ffault_q;
  assign bus.fetch_data     = ffault_q ? HALT_WORD : rd_data;

endmodule

// File: doc/loadable_instruction_ram.md
# loadable_instruction_ram

Parametrised instruction memory with a runtime program-download port, replacing fixed-content instruction ROMs. A loader (UART bridge or testbench) streams a program in with a valid/ready handshake. The processor then fetches through a registered read port that flags out-of-range fetches. While no valid program is present, the block holds the processor in stall.

## Interface
- DATA_WIDTH, 32, instruction word width
- ADDR_WIDTH, 10, fetch/write address width
- DEPTH, 1024, number of words; must satisfy DEPTH <= 2**ADDR_WIDTH
- HALT_WORD, all-zeros, word returned on an out-of-range fetch

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- load_start  in  1  one-cycle pulse: begin (re)download at address 0
- load_valid  in  1  loader has a word on load_data
- load_data  in  DATA_WIDTH  word to write
- load_last  in  1  qualifies the final word of the program
- load_ready  out  1  block accepts a beat this cycle
- load_error  out  1  sticky: DEPTH words accepted without load_last
- program_length  out  ADDR_WIDTH+1  number of valid words (0..DEPTH)
- cpu_hold  out  1  processor must stall
- fetch_enable  in  1  fetch request
- fetch_address  in  ADDR_WIDTH  word address
- fetch_data  out  DATA_WIDTH  fetched word
- fetch_valid  out  1  fetch_data is a fresh response
- fetch_fault  out  1  response was out of range (address >= program_length)

## Operation
- FSM states: EMPTY, LOAD, RUN.
- Reset values:
  - state = EMPTY
  - load_ready = 0, load_error = 0, program_length = 0
  - cpu_hold = 1
  - fetch_valid = 0, fetch_fault = 0, fetch_data = 0
  - RAM contents are not cleared.
- EMPTY: load_start moves to LOAD; all other inputs are ignored.
- LOAD:
  - load_ready = 1 and cpu_hold = 1; the write pointer starts at 0.
  - A beat is accepted when load_valid && load_ready: it writes mem[ptr] and increments ptr.
  - Beat accepted with load_last: program_length <= ptr+1, go to RUN.
  - Beat accepted at ptr == DEPTH-1 without load_last: program_length <= DEPTH, load_error <= 1, go to RUN.
- RUN:
  - cpu_hold = 0 and load_ready = 0; load_valid is ignored.
  - load_start moves to LOAD, clears load_error and sets program_length <= 0.
- load_start in LOAD restarts the pointer at 0 and sets program_length <= 0. A beat presented in the same cycle is not accepted, because load_ready is forced to 0 in that cycle.
- Fetch:
  - Serviced only in RUN. In EMPTY or LOAD, fetch_enable is ignored and fetch_valid = 0.
  - In range (fetch_address < program_length): fetch_data <= mem[fetch_address], fetch_fault <= 0.
  - Out of range: fetch_data <= HALT_WORD, fetch_fault <= 1.
- When fetch_enable = 0, fetch_data and fetch_fault hold their previous values and fetch_valid = 0.
- Width rule: the comparison zero-extends fetch_address to ADDR_WIDTH+1 bits. Addresses >= DEPTH are always faults and must never index the RAM.

## Timing
- Fetch latency is 1 cycle: a request in cycle N produces fetch_data, fetch_fault and fetch_valid in cycle N+1.
- Back-to-back fetches are allowed every cycle.
- Write latency is 1 cycle: a word accepted in cycle N is readable by a fetch issued in cycle N+1 or later.
- Final-beat handoff:
  - The final beat is accepted in cycle N.
  - In N+1: state = RUN, cpu_hold = 0, program_length is valid.
  - The first fetch response can appear in N+2.
- load_start in RUN (cycle N): cpu_hold = 1 and load_ready = 1 from N+1. A fetch issued in cycle N still returns a response in N+1.
- Reset asserted mid-load: in the next cycle all outputs take their reset values and any partial program is discarded (program_length = 0).

## Structure
- Shared package: state enum (EMPTY/LOAD/RUN) and the default HALT_WORD constant, so the decoder can recognise halts.
- One sub-module: instruction_ram_core, a simple dual-port synchronous RAM (one write port, one registered read port) parametrised by DATA_WIDTH, ADDR_WIDTH and DEPTH.
- FSM, pointer, length and fetch-range logic live in the top module.

## Test plan
- Reset, then fetch address 0 -> fetch_valid = 0, cpu_hold = 1, program_length = 0.
- Load 69 words (word i = 0x48000000+i, load_last on the 69th), then fetch addresses 0, 68 and 69:
  - addresses 0 and 68 return the loaded words one cycle later with fetch_fault = 0;
  - address 69 returns HALT_WORD with fetch_fault = 1;
  - program_length = 69.
- Toggle load_valid randomly during a 10-word load -> exactly 10 writes, in order, and no beat is accepted while load_ready = 0.
- With DEPTH = 16, stream 20 words without load_last -> 16 beats accepted, load_error = 1, program_length = 16, load_ready = 0 from the 17th cycle onward.
- Reset asserted after 5 of 10 beats -> state EMPTY, program_length = 0. Then pulse load_start and load 3 words -> program_length = 3.
- In RUN, pulse load_start with load_valid held high in the same cycle -> that beat is not accepted. Load 2 new words -> the old address 5 now faults and addresses 0-1 return the new data.
